// File: rtl/stdcell_test_sequencer.sv
// Self-test sequencer for the 19-cell standard-cell test array.
// Sweeps the shared 4-bit stimulus bus through all 16 patterns for a
// programmable number of loops, samples the cell outputs after a settle
// delay and accumulates fail flags and a mismatch count. Wishbone slave.
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | waiting for START; results of the last run are readable
// APPLY    | stimulus on the bus, settle counter loaded
// SETTLE   | counting down the settle cycles
// SAMPLE   | compare cell outputs with the golden vector
// NEXT     | advance stimulus / loop, or finish
// DONE     | one cycle before returning to IDLE with DONE set
module stdcell_test_sequencer #(
    parameter int SETTLE_W = 8,
    parameter int LOOP_W   = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [3:0]  stim_o,
    output logic        stim_oe_o,
    input  logic [18:0] dut_out_i
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_NEXT   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;
    logic [SETTLE_W-1:0] ctrl_settle_q, ctrl_settle_d;
    logic [LOOP_W-1:0]   ctrl_loops_q, ctrl_loops_d;
    logic [SETTLE_W-1:0] run_settle_q, run_settle_d;
    logic [LOOP_W-1:0]   run_lmax_q, run_lmax_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [LOOP_W-1:0]   loop_q, loop_d;
    logic [3:0]          stim_q, stim_d;
    logic                done_q, done_d;
    logic [18:0]         fail_mask_q, fail_mask_d;
    logic [31:0]         mcnt_q, mcnt_d;
    logic [3:0]          last_stim_q, last_stim_d;
    logic [4:0]          last_cell_q, last_cell_d;

    logic                wb_req, ctrl_wr, start_p, abort_p;
    logic [2:0]          reg_adr;
    logic [SETTLE_W-1:0] new_settle, new_settle_eff;
    logic [LOOP_W-1:0]   new_loops, new_lmax;
    logic [18:0]         mism;
    logic [4:0]          mism_pop, mism_low;
    logic [32:0]         mcnt_sum;
    logic [31:0]         rd_data;
    logic                unused_ok;

    // Golden response of every cell for stimulus {d,c,b,a}
    function automatic logic [18:0] golden(input logic [3:0] s);
        logic a, b, c, d;
        logic [18:0] g;
        a = s[0]; b = s[1]; c = s[2]; d = s[3];
        g[0]  = a & b;
        g[1]  = a & b;
        g[2]  = ~((a & b) | c);
        g[3]  = ~((a & b) | (c & d));
        g[4]  = a;
        g[5]  = a;
        g[6]  = a;
        g[7]  = ~a;
        g[8]  = ~a;
        g[9]  = ~a;
        g[10] = ~a;
        g[11] = ~a;
        g[12] = c ? b : a;
        g[13] = ~(a & b);
        g[14] = ~(a & b & c);
        g[15] = a | b;
        g[16] = a | b;
        g[17] = ~(a ^ b);
        g[18] = a ^ b;
        return g;
    endfunction

    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_dat_i};

    // Bus request decode; the register file sees one request per ack
    always_comb begin
        reg_adr        = wbs_adr_i[4:2];
        wb_req         = wbs_stb_i & wbs_cyc_i & ~ack_q;
        ctrl_wr        = wb_req & wbs_we_i & (reg_adr == 3'd0);
        abort_p        = ctrl_wr & wbs_dat_i[1];
        start_p        = ctrl_wr & wbs_dat_i[0] & ~wbs_dat_i[1];
        new_settle     = wbs_dat_i[8 +: SETTLE_W];
        new_loops      = wbs_dat_i[16 +: LOOP_W];
        new_settle_eff = (new_settle == '0) ? SETTLE_W'(1) : new_settle;
        new_lmax       = (new_loops == '0) ? '0 : new_loops - LOOP_W'(1);
    end

    // Compare the cell outputs with the golden vector for the current stimulus
    always_comb begin
        mism     = dut_out_i ^ golden(stim_q);
        mism_pop = '0;
        mism_low = '0;
        for (int i = 18; i >= 0; i--) begin
            mism_pop = mism_pop + {4'd0, mism[i]};
            if (mism[i]) mism_low = 5'(i);
        end
        mcnt_sum = {1'b0, mcnt_q} + {28'd0, mism_pop};
    end

    // Register read mux
    always_comb begin
        rd_data = '0;
        unique case (reg_adr)
            3'd0: begin
                rd_data[8 +: SETTLE_W] = ctrl_settle_q;
                rd_data[16 +: LOOP_W]  = ctrl_loops_q;
            end
            3'd1:    rd_data[2:0] = {done_q & (fail_mask_q == '0), done_q, state_q != ST_IDLE};
            3'd2:    rd_data[18:0] = fail_mask_q;
            3'd3:    rd_data = mcnt_q;
            3'd4:    rd_data[12:0] = {last_cell_q, 4'd0, last_stim_q};
            default: rd_data = '0;
        endcase
    end

    // FSM next state; ABORT overrides every busy transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start_p) state_d = ST_APPLY;
            ST_APPLY:  state_d = ST_SETTLE;
            ST_SETTLE: if (settle_cnt_q <= SETTLE_W'(1)) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = ST_NEXT;
            ST_NEXT:   state_d = (stim_q != 4'd15 || loop_q < run_lmax_q) ? ST_APPLY : ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && abort_p) state_d = ST_IDLE;
    end

    // FSM outputs
    always_comb begin
        stim_o    = stim_q;
        stim_oe_o = (state_q != ST_IDLE);
        wbs_ack_o = ack_q;
        wbs_dat_o = dat_q;
    end

    // Datapath and register-file next values
    always_comb begin
        ack_d         = wb_req;
        dat_d         = wb_req ? rd_data : '0;
        ctrl_settle_d = ctrl_wr ? new_settle : ctrl_settle_q;
        ctrl_loops_d  = ctrl_wr ? new_loops : ctrl_loops_q;
        run_settle_d  = run_settle_q;
        run_lmax_d    = run_lmax_q;
        settle_cnt_d  = settle_cnt_q;
        loop_d        = loop_q;
        stim_d        = stim_q;
        done_d        = done_q;
        fail_mask_d   = fail_mask_q;
        mcnt_d        = mcnt_q;
        last_stim_d   = last_stim_q;
        last_cell_d   = last_cell_q;
        unique case (state_q)
            ST_IDLE: if (start_p) begin
                // Latch the run config so CTRL writes mid-run cannot alter it
                run_settle_d = new_settle_eff;
                run_lmax_d   = new_lmax;
                stim_d       = '0;
                loop_d       = '0;
                done_d       = 1'b0;
                fail_mask_d  = '0;
                mcnt_d       = '0;
                last_stim_d  = '0;
                last_cell_d  = '0;
            end
            ST_APPLY:  settle_cnt_d = run_settle_q;
            ST_SETTLE: settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
            ST_SAMPLE: if (!abort_p) begin
                fail_mask_d = fail_mask_q | mism;
                mcnt_d      = mcnt_sum[32] ? 32'hFFFF_FFFF : mcnt_sum[31:0];
                if (mism != '0) begin
                    last_stim_d = stim_q;
                    last_cell_d = mism_low;
                end
            end
            ST_NEXT: if (!abort_p) begin
                if (stim_q != 4'd15) begin
                    stim_d = stim_q + 4'd1;
                end else if (loop_q < run_lmax_q) begin
                    stim_d = '0;
                    loop_d = loop_q + LOOP_W'(1);
                end
            end
            ST_DONE: if (!abort_p) done_d = 1'b1;
            default: ;
        endcase
    end

    // State and register flops, synchronous active-low reset
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q       <= ST_IDLE;
            ack_q         <= 1'b0;
            dat_q         <= '0;
            ctrl_settle_q <= '0;
            ctrl_loops_q  <= '0;
            run_settle_q  <= '0;
            run_lmax_q    <= '0;
            settle_cnt_q  <= '0;
            loop_q        <= '0;
            stim_q        <= '0;
            done_q        <= 1'b0;
            fail_mask_q   <= '0;
            mcnt_q        <= '0;
            last_stim_q   <= '0;
            last_cell_q   <= '0;
        end else begin
            state_q       <= state_d;
            ack_q         <= ack_d;
            dat_q         <= dat_d;
            ctrl_settle_q <= ctrl_settle_d;
            ctrl_loops_q  <= ctrl_loops_d;
            run_settle_q  <= run_settle_d;
            run_lmax_q    <= run_lmax_d;
            settle_cnt_q  <= settle_cnt_d;
            loop_q        <= loop_d;
            stim_q        <= stim_d;
            done_q        <= done_d;
            fail_mask_q   <= fail_mask_d;
            mcnt_q        <= mcnt_d;
            last_stim_q   <= last_stim_d;
            last_cell_q   <= last_cell_d;
        end
    end

endmodule

// File: tb/tb_stdcell_test_sequencer.sv
// Bench for stdcell_test_sequencer: a faultable cell-array model feeds the
// sequencer, and a sweep-level reference computes the expected results.
module tb_stdcell_test_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic [3:0]  stim;
    logic        stim_oe;
    logic [18:0] cell_out;

    logic [18:0] inv_m, sa0_m, sa1_m;
    int          cyc_n = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    stdcell_test_sequencer dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat),
        .stim_o   (stim),
        .stim_oe_o(stim_oe),
        .dut_out_i(cell_out)
    );

    // Cell truth tables, straight from the cell library list
    function automatic logic [18:0] cell_fn(input logic [3:0] s);
        logic a, b, c, d;
        logic [18:0] g;
        {d, c, b, a} = s;
        g = {a ^ b, ~(a ^ b), a | b, a | b, ~(a & b & c), ~(a & b), (c ? b : a),
             {5{~a}}, {3{a}}, ~((a & b) | (c & d)), ~((a & b) | c), a & b, a & b};
        return g;
    endfunction

    function automatic logic [18:0] faulty(input logic [3:0] s);
        return ((cell_fn(s) ^ inv_m) & ~sa0_m) | sa1_m;
    endfunction

    // Cell array with one cycle of propagation delay
    always @(posedge clk) cell_out <= faulty(stim);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] q);
        bit got_ack = 0;
        @(posedge clk); #1;
        stb = 1; cyc = 1; we = w; adr = a; wdat = d;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) begin got_ack = 1; break; end
        end
        q = rdat;
        stb = 0; cyc = 0; we = 0;
        if (!got_ack) chk("ack_timeout", {31'd0, ack}, 32'd1);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(1'b1, a, d, q);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] q);
        wb_xfer(1'b0, a, 32'd0, q);
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && stim_oe; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Full run checked against the sweep-level reference
    task automatic run_check(input string tag, input logic [15:0] loops, input logic [7:0] settle);
        int          l_eff, s_eff, c0, exp_cnt;
        logic [18:0] m, exp_mask;
        logic [31:0] exp_last, q;
        l_eff = (loops == 0) ? 1 : int'(loops);
        s_eff = (settle == 0) ? 1 : int'(settle);
        exp_cnt = 0; exp_mask = '0; exp_last = '0;
        for (int s = 0; s < 16; s++) begin
            m = faulty(4'(s)) ^ cell_fn(4'(s));
            exp_cnt += $countones(m) * l_eff;
            exp_mask |= m;
            if (m != 0) begin
                for (int k = 18; k >= 0; k--) if (m[k]) exp_last = (k << 8) | s;
            end
        end
        wb_write(32'h0, {loops, settle, 8'h01});
        c0 = cyc_n;
        chk({tag, "_busy"}, {31'd0, stim_oe}, 32'd1);
        wait_idle(20000);
        chk({tag, "_cycles"}, cyc_n - c0, l_eff * 16 * (s_eff + 3) + 1);
        wb_read(32'h4, q);  chk({tag, "_status"}, q, (exp_mask == 0) ? 32'd6 : 32'd2);
        wb_read(32'h8, q);  chk({tag, "_failmask"}, q, {13'd0, exp_mask});
        wb_read(32'hC, q);  chk({tag, "_mcnt"}, q, exp_cnt);
        wb_read(32'h10, q); chk({tag, "_lastfail"}, q, exp_last);
        wb_read(32'h0, q);  chk({tag, "_ctrl"}, q, {loops, settle, 8'h00});
    endtask

    initial begin
        logic [31:0] q;
        int          c0, acks;
        logic [5:0]  pat;

        stb = 0; cyc = 0; we = 0; sel = 4'hF; adr = 0; wdat = 0;
        inv_m = 0; sa0_m = 0; sa1_m = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", {31'd0, ack}, 0);
        chk("rst_dat", rdat, 0);
        chk("rst_stim", {28'd0, stim}, 0);
        chk("rst_oe", {31'd0, stim_oe}, 0);
        rst_n = 1;
        wb_read(32'h4, q); chk("rst_status", q, 0);
        wb_read(32'h0, q); chk("rst_ctrl", q, 0);

        run_check("clean", 16'd1, 8'd2);

        sa0_m = 19'h80;
        run_check("inv_sa0", 16'd3, 8'd0);

        sa0_m = 0; inv_m = 19'h40008;
        run_check("multi", 16'd1, 8'd1);

        // RO writes ignored, unmapped addresses read zero
        wb_write(32'hC, 32'h0);
        wb_read(32'hC, q); chk("ro_write", q, 32);
        for (int a = 5; a < 8; a++) begin
            wb_read(32'(a << 2), q); chk("unmapped", q, 0);
        end

        // Abort once stim reaches 5
        inv_m = 0; sa0_m = 19'h80;
        wb_write(32'h0, {16'd1, 8'd2, 8'h01});
        for (int i = 0; i < 500 && stim != 4'd5; i++) begin @(posedge clk); #1; end
        wb_write(32'h0, {16'd1, 8'd2, 8'h02});
        chk("abort_oe", {31'd0, stim_oe}, 0);
        @(posedge clk); #1;
        chk("abort_oe2", {31'd0, stim_oe}, 0);
        wb_read(32'h4, q);  chk("abort_status", q, 0);
        wb_read(32'hC, q);  chk("abort_mcnt", q, 3);
        wb_read(32'h8, q);  chk("abort_mask", q, 32'h80);
        wb_read(32'h10, q); chk("abort_last", q, 32'h0704);

        // START while busy must not restart or stretch the run
        sa0_m = 0;
        wb_write(32'h0, {16'd1, 8'd1, 8'h01});
        c0 = cyc_n;
        repeat (20) @(posedge clk);
        wb_write(32'h0, {16'd1, 8'd1, 8'h01});
        wait_idle(2000);
        chk("restart_cycles", cyc_n - c0, 65);

        // Held strobe: ack every other cycle
        @(posedge clk); #1;
        stb = 1; cyc = 1; we = 0; adr = 32'h4;
        acks = 0; pat = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            pat[i] = ack;
            acks += int'(ack);
        end
        stb = 0; cyc = 0;
        chk("b2b_acks", acks, 3);
        chk("b2b_pattern", {26'd0, pat}, 32'h15);

        // Randomized fault runs
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 2) == 0) begin
                inv_m = 0; sa0_m = 0; sa1_m = 0;
            end else begin
                inv_m = 19'($urandom & $urandom & $urandom);
                sa0_m = 19'($urandom & $urandom & $urandom);
                sa1_m = 19'($urandom & $urandom & $urandom);
            end
            run_check("rand", 16'($urandom_range(0, 3)), 8'($urandom_range(0, 5)));
        end

        // Reset in the middle of a run
        inv_m = 19'h1;
        wb_write(32'h0, {16'd2, 8'd3, 8'h01});
        repeat (30) @(posedge clk);
        #1 rst_n = 0;
        @(posedge clk); #1;
        chk("midrst_oe", {31'd0, stim_oe}, 0);
        chk("midrst_stim", {28'd0, stim}, 0);
        chk("midrst_ack", {31'd0, ack}, 0);
        rst_n = 1;
        wb_read(32'h4, q); chk("midrst_status", q, 0);
        wb_read(32'hC, q); chk("midrst_mcnt", q, 0);
        wb_read(32'h0, q); chk("midrst_ctrl", q, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stdcell_test_sequencer.md
# stdcell_test_sequencer

Wishbone-controlled self-test sequencer for the 19-cell standard-cell test array on the test wafer. It drives a shared 4-bit stimulus bus into every cell's inputs, sweeps all 16 input combinations for a programmable number of loops, and samples all 19 cell outputs after a programmable settle time. Each sample is compared against an internal golden model, and the block accumulates per-cell fail flags and a mismatch count. It sits in the user project beside the cell array; the wrapper muxes the cell inputs from the IO/LA pins to `stim_o` while `stim_oe_o` is high.

## Interface
- `SETTLE_W`, default 8: width of the settle-cycle field.
- `LOOP_W`, default 16: width of the loop-count field, at most 16.
- `wb_clk_i`  in  1  single clock; all logic is on its rising edge.
- `wb_rst_ni`  in  1  synchronous, active-low reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone strobe, cycle and write-enable.
- `wbs_sel_i`  in  4  ignored; every write is a full-word write.
- `wbs_adr_i`  in  32  bits [4:2] select the register; other bits are ignored.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  acknowledge.
- `wbs_dat_o`  out  32  registered read data.
- `stim_o`  out  4  stimulus {d,c,b,a}, fanned out to all cell inputs.
- `stim_oe_o`  out  1  high while busy; selects the sequencer as the cell-input source.
- `dut_out_i`  in  19  cell outputs, index = cell number below.

## Operation
Cell numbering and golden functions:
- 0 AND2X1, 1 AND2X2: a&b.
- 2 AOI21X1: ~((a&b)|c).
- 3 AOI22X1: ~((a&b)|(c&d)).
- 4 BUFX2, 5 BUFX4, 6 CLKBUF1: a.
- 7 INV, 8 INVX1, 9 INVX2, 10 INVX4, 11 INVX8: ~a.
- 12 MUX2X1: c ? b : a (c is the select input).
- 13 NAND2X1: ~(a&b).
- 14 NAND3X1: ~(a&b&c).
- 15 OR2X1, 16 OR2X2: a|b.
- 17 XNOR2X1: ~(a^b).
- 18 XOR2X1: a^b.

Registers (word address = `wbs_adr_i[4:2]`):
- 0 CTRL (R/W):
  - [0] START: write-1 pulse, reads 0.
  - [1] ABORT: write-1 pulse, reads 0.
  - [15:8] SETTLE: settle cycles; a value of 0 is treated as 1.
  - [31:16] LOOPS: number of sweeps; a value of 0 is treated as 1.
- 1 STATUS (RO): [0] BUSY, [1] DONE, [2] PASS (DONE and the fail mask is zero).
- 2 FAIL_MASK (RO): [18:0] sticky per-cell fail bits.
- 3 MISMATCH_CNT (RO): 32-bit count, saturates at 0xFFFFFFFF.
- 4 LAST_FAIL (RO): [3:0] stimulus value, [12:8] lowest failing cell index of the most recent failing sample.
- Addresses 5–7 read as 0. Writes to RO registers are ignored.

FSM states: IDLE, APPLY, SETTLE, SAMPLE, NEXT, DONE.
- IDLE, START: clear FAIL_MASK, MISMATCH_CNT, LAST_FAIL and DONE; set stim=0, loop=0; go to APPLY.
- APPLY (1 cycle): `stim_o` already holds the value; load the settle counter; go to SETTLE.
- SETTLE: count down SETTLE cycles, then go to SAMPLE.
- SAMPLE (1 cycle): compare `dut_out_i` with the golden vector for `stim_o`.
  - OR the mismatch bits into FAIL_MASK.
  - Add popcount(mismatch) to MISMATCH_CNT, saturating.
  - If any mismatch, update LAST_FAIL.
- NEXT (1 cycle):
  - stim < 15: stim+1, go to APPLY.
  - stim = 15 and loop < LOOPS-1: stim=0, loop+1, go to APPLY.
  - Otherwise go to DONE.
- DONE (1 cycle): set DONE, go to IDLE.
- START while BUSY is ignored.
- ABORT while BUSY: go to IDLE next cycle with DONE=0; results so far are kept. ABORT while idle has no effect.
- START and ABORT in the same write: ABORT wins.
- BUSY = state ≠ IDLE. `stim_oe_o` = BUSY.

## Timing
- Reset values:
  - `wbs_ack_o`=0, `wbs_dat_o`=0, `stim_o`=0, `stim_oe_o`=0.
  - State IDLE; all registers 0 (LOOPS=0 and SETTLE=0 mean 1).
- Wishbone: when `stb&cyc` is high and ack is low, ack goes high for exactly one cycle on the next edge, with read data valid in that cycle.
  - No back-to-back acks; a held strobe is acked every other cycle.
  - Writes take effect on the edge that asserts ack.
- The START write edge enters APPLY, and BUSY reads 1 from the next cycle.
- Per-pattern cost is S+3 cycles, where S is the effective settle value: APPLY 1, SETTLE S, SAMPLE 1, NEXT 1.
- Total from the START edge to the DONE=1 edge is L·16·(S+3)+1 cycles, where L is the effective loop count.
- `dut_out_i` is sampled exactly S+1 cycles after `stim_o` changes.
- Reset mid-run restores all reset values on the next edge.

## Test plan
- Reset values: drive `wb_rst_ni`=0 for 2 cycles → all outputs 0; STATUS=0; CTRL reads 0.
- Clean run: golden-model bench, CTRL={LOOPS=1, SETTLE=2} → DONE after 16·5+1=81 cycles, STATUS=0b110, FAIL_MASK=0, MISMATCH_CNT=0.
- Stuck-at on INV: cell 7 stuck at 0, LOOPS=3, SETTLE=0 → MISMATCH_CNT=24, FAIL_MASK=0x80, LAST_FAIL stim=14, cell=7, PASS=0.
- Multi-fault: cells 3 and 18 inverted, LOOPS=1 → MISMATCH_CNT=32, FAIL_MASK=0x40008, LAST_FAIL cell=3, stim=15.
- Abort mid-run: ABORT at stim=5 → IDLE within 1 cycle, DONE=0, `stim_oe_o`=0, counts retained.
- Control edges:
  - START during BUSY → no restart; the run length is unchanged.
  - Back-to-back reads → ack every other cycle.
  - Reads from addresses 5–7 → 0.
